// File: rtl/ram_port_arbiter_if.sv
// Client-side bundle for ram_port_arbiter: N_RD read channels with a shared return bus
// and one write channel.
interface ram_port_arbiter_if #(
    parameter int unsigned N_RD   = 2,
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
);
    logic [N_RD-1:0]        rd_req;
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD-1:0]        rd_ready;
    logic [N_RD-1:0]        rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic                   wr_req;
    logic                   wr_ready;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic [DATA_W/8-1:0]    wr_strb;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_strb,
        input  rd_ready, rd_valid, rd_data, wr_ready
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_strb,
        output rd_ready, rd_valid, rd_data, wr_ready
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one fixed-latency single-port memory among N_RD read channels and one write channel.
// Optional traffic counters are enabled with the RAM_PORT_PERF_CNT_EN macro.
module ram_port_arbiter #(
    parameter int unsigned N_RD     = 2,
    parameter int unsigned ADDR_W   = 28,
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned WR_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    ram_port_arbiter_if.slave           bus,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [DATA_W/8-1:0]         mem_wstrb,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic [2+$clog2(N_RD)-1:0]   perf_sel,
    output logic [31:0]                 perf_data
);
    localparam int unsigned PTR_W  = (N_RD > 1) ? $clog2(N_RD) : 1;
    localparam int unsigned RUN_W  = $clog2(WR_BURST + 1);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [PTR_W-1:0] rr_q, rr_d;
    logic [RUN_W-1:0] wr_run_q, wr_run_d;
    logic             any_rd, wr_block, wr_gnt, rd_any_gnt;
    logic [N_RD-1:0]  rd_gnt;
    logic [PTR_W-1:0] rd_idx;
    int unsigned      cand;

    logic [RD_LAT-1:0] tag_vld_q;
    logic [PTR_W-1:0]  tag_ch_q [RD_LAT];

    assign any_rd   = |bus.rd_req;
    assign wr_block = (wr_run_q == RUN_W'(WR_BURST)) && any_rd;
    // Grants are gated by rstn so every output is 0 while reset is held.
    assign wr_gnt   = rstn && bus.wr_req && !wr_block;

    // Scan downwards so the channel closest to the rr pointer is the last one assigned.
    always_comb begin
        rd_idx     = '0;
        rd_any_gnt = 1'b0;
        cand       = 0;
        if (rstn && !wr_gnt) begin
            for (int i = int'(N_RD) - 1; i >= 0; i--) begin
                cand = (32'(rr_q) + 32'(i)) % N_RD;
                if (bus.rd_req[cand]) begin
                    rd_idx     = PTR_W'(cand);
                    rd_any_gnt = 1'b1;
                end
            end
        end
        rd_gnt = '0;
        rd_gnt[rd_idx] = rd_any_gnt;
    end

    always_comb begin
        rr_d = rr_q;
        if (rd_any_gnt) begin
            rr_d = (rd_idx == PTR_W'(N_RD - 1)) ? '0 : rd_idx + PTR_W'(1);
        end
        wr_run_d = '0;
        if (wr_gnt && any_rd) begin
            wr_run_d = (wr_run_q == RUN_W'(WR_BURST)) ? wr_run_q : wr_run_q + RUN_W'(1);
        end
    end

    always_comb begin
        mem_en    = wr_gnt | rd_any_gnt;
        mem_we    = wr_gnt;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (wr_gnt) begin
            mem_addr  = bus.wr_addr;
            mem_wdata = bus.wr_data;
            mem_wstrb = bus.wr_strb;
        end else if (rd_any_gnt) begin
            mem_addr  = bus.rd_addr[rd_idx*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q      <= '0;
            wr_run_q  <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                tag_ch_q[i] <= '0;
            end
        end else begin
            rr_q         <= rr_d;
            wr_run_q     <= wr_run_d;
            tag_vld_q[0] <= rd_any_gnt;
            tag_ch_q[0]  <= rd_idx;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_ch_q[i]  <= tag_ch_q[i-1];
            end
        end
    end

    always_comb begin
        bus.rd_valid = '0;
        bus.rd_valid[tag_ch_q[RD_LAT-1]] = tag_vld_q[RD_LAT-1];
        bus.rd_data  = tag_vld_q[RD_LAT-1] ? mem_rdata : '0;
    end

    assign bus.rd_ready = rd_gnt;
    assign bus.wr_ready = wr_gnt;

`ifdef RAM_PORT_PERF_CNT_EN
    localparam int unsigned CH_W = $clog2(N_RD);

    logic [31:0] rd_bytes_q [N_RD];
    logic [31:0] rd_stall_q [N_RD];
    logic [31:0] wr_bytes_q, wr_stall_q, perf_data_q, perf_data_d, strb_cnt;
    int unsigned sel_chan;
    logic [1:0]  sel_type;

    always_comb begin
        strb_cnt = '0;
        for (int b = 0; b < int'(STRB_W); b++) begin
            strb_cnt = strb_cnt + 32'(bus.wr_strb[b]);
        end
    end

    // Masking rather than slicing keeps N_RD == 1 (empty chan field) legal.
    always_comb begin
        sel_chan    = 32'(perf_sel) & ((32'd1 << CH_W) - 32'd1);
        sel_type    = 2'(32'(perf_sel) >> CH_W);
        perf_data_d = '0;
        case (sel_type)
            2'd0:    if (sel_chan < N_RD) perf_data_d = rd_bytes_q[sel_chan];
            2'd1:    if (sel_chan < N_RD) perf_data_d = rd_stall_q[sel_chan];
            2'd2:    perf_data_d = wr_bytes_q;
            default: perf_data_d = wr_stall_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(N_RD); i++) begin
                rd_bytes_q[i] <= '0;
                rd_stall_q[i] <= '0;
            end
            wr_bytes_q  <= '0;
            wr_stall_q  <= '0;
            perf_data_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_RD); i++) begin
                if (rd_gnt[i]) rd_bytes_q[i] <= rd_bytes_q[i] + 32'(STRB_W);
                if (bus.rd_req[i] && !rd_gnt[i]) rd_stall_q[i] <= rd_stall_q[i] + 32'd1;
            end
            if (wr_gnt) wr_bytes_q <= wr_bytes_q + strb_cnt;
            if (bus.wr_req && !wr_gnt) wr_stall_q <= wr_stall_q + 32'd1;
            perf_data_q <= perf_data_d;
        end
    end

    assign perf_data = perf_data_q;
`else
    logic unused_perf_sel;
    assign unused_perf_sel = ^perf_sel;
    assign perf_data       = '0;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural memory and a return-data scoreboard.
module tb_ram_port_arbiter;
    localparam int unsigned N_RD     = 2;
    localparam int unsigned ADDR_W   = 28;
    localparam int unsigned DATA_W   = 128;
    localparam int unsigned RD_LAT   = 2;
    localparam int unsigned WR_BURST = 4;
    localparam int unsigned SEL_W    = 2 + $clog2(N_RD);

    typedef logic [DATA_W-1:0] w_t;
    typedef struct packed {
        logic [N_RD-1:0] vld;
        w_t              data;
    } ret_t;

    logic clk = 1'b0;
    logic rstn;
    logic mem_en, mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    w_t                  mem_wdata, mem_rdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [SEL_W-1:0]    perf_sel;
    logic [31:0]         perf_data;

    ram_port_arbiter_if #(.N_RD(N_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(
        .N_RD(N_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .WR_BURST(WR_BURST)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .perf_sel(perf_sel), .perf_data(perf_data)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    ret_t sb_q[$];
    w_t   ref_mem [256];
    logic init_mem;

    function automatic w_t init_word(int i);
        return {32'hA5A5_0000 + 32'(i), 32'h1234_0000 + 32'(i), ~32'(i), 32'(i) * 32'h0101_0101};
    endfunction

    function automatic w_t merge(w_t old, w_t d, logic [DATA_W/8-1:0] s);
        w_t r = old;
        for (int b = 0; b < int'(DATA_W / 8); b++) begin
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    // Behavioural memory: fixed RD_LAT read pipeline, byte-masked writes.
    w_t mem_model [256];
    w_t rpipe [RD_LAT];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            mem_model[mem_addr[7:0]] <= merge(mem_model[mem_addr[7:0]], mem_wdata, mem_wstrb);
        end
        rpipe[0] <= (mem_en && !mem_we) ? mem_model[mem_addr[7:0]] : '0;
        for (int i = 1; i < int'(RD_LAT); i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[RD_LAT-1];

    task automatic check(input string tag, input w_t obs, input w_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_req  = '0;
        bus.wr_req  = 1'b0;
        bus.wr_strb = '0;
    endtask

    task automatic set_raddr(input int ch, input int addr);
        bus.rd_addr[ch*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    endtask

    task automatic push_ret(input int ch, input w_t data);
        ret_t e;
        e.vld  = N_RD'(1 << ch);
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Return checker: every rd_valid must match the oldest expected return.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.rd_valid != '0) begin
                ret_t e = '0;
                if (sb_q.size() != 0) e = sb_q.pop_front();
                check("ret_valid", w_t'(bus.rd_valid), w_t'(e.vld));
                check("ret_data", bus.rd_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        w_t wd;
        w_t exp5;
        int exp_rr;
        logic exp_w;

        rstn = 1'b0;
        init_mem = 1'b1;
        bus.rd_addr = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        perf_sel = '0;
        idle();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        tick();
        tick();
        init_mem = 1'b0;
        @(negedge clk);
        check("rst_rd_ready", w_t'(bus.rd_ready), w_t'(0));
        check("rst_wr_ready", w_t'(bus.wr_ready), w_t'(0));
        check("rst_mem_en", w_t'(mem_en), w_t'(0));
        check("rst_rd_valid", w_t'(bus.rd_valid), w_t'(0));
        check("rst_perf", w_t'(perf_data), w_t'(0));
        tick();
        rstn = 1'b1;

        // Single read: grant same cycle, return RD_LAT cycles later.
        tick();
        bus.rd_req = 2'b01;
        set_raddr(0, 'h10);
        @(negedge clk);
        check("t1_ready", w_t'(bus.rd_ready), w_t'(2'b01));
        check("t1_mem_en", w_t'(mem_en), w_t'(1));
        check("t1_mem_we", w_t'(mem_we), w_t'(0));
        check("t1_mem_addr", w_t'(mem_addr), w_t'('h10));
        push_ret(0, ref_mem['h10]);
        exp_rr = 1;
        tick();
        idle();
        @(negedge clk);
        check("t1_lat_early", w_t'(bus.rd_valid), w_t'(0));
        @(negedge clk);
        check("t1_valid", w_t'(bus.rd_valid), w_t'(2'b01));
        check("t1_data", bus.rd_data, init_word('h10));

        // Both channels continuously: alternating grants, ordered back-to-back returns.
        tick();
        bus.rd_req = 2'b11;
        set_raddr(0, 'h20);
        set_raddr(1, 'h30);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t2_grant", w_t'(bus.rd_ready), w_t'(1 << exp_rr));
            push_ret(exp_rr, ref_mem[(exp_rr == 1) ? 'h30 : 'h20]);
            exp_rr = 1 - exp_rr;
            tick();
        end
        idle();
        repeat (RD_LAT + 1) tick();

        // Write starvation guard: W,W,W,W,R0 repeated.
        bus.wr_req  = 1'b1;
        bus.wr_strb = '1;
        bus.rd_req  = 2'b01;
        set_raddr(0, 'h11);
        for (int c = 0; c < 10; c++) begin
            bus.wr_addr = ADDR_W'('h40 + c);
            wd = {$urandom, $urandom, $urandom, $urandom};
            bus.wr_data = wd;
            @(negedge clk);
            exp_w = ((c % 5) != 4);
            check("t3_wr_grant", w_t'(bus.wr_ready), w_t'(exp_w));
            check("t3_rd_grant", w_t'(bus.rd_ready), w_t'(exp_w ? 2'b00 : 2'b01));
            if (exp_w) begin
                check("t3_mem_we", w_t'(mem_we), w_t'(1));
                check("t3_mem_addr", w_t'(mem_addr), w_t'('h40 + c));
                ref_mem['h40 + c] = wd;
            end else begin
                push_ret(0, ref_mem['h11]);
            end
            tick();
        end
        idle();
        repeat (RD_LAT + 1) tick();
        bus.rd_req = 2'b10;
        set_raddr(1, 'h42);
        @(negedge clk);
        check("t3_readback_grant", w_t'(bus.rd_ready), w_t'(2'b10));
        push_ret(1, ref_mem['h42]);
        tick();
        idle();

        // Partial-strobe write, zero-strobe write, then read both back.
        bus.wr_req  = 1'b1;
        bus.wr_addr = ADDR_W'(5);
        bus.wr_data = '1;
        bus.wr_strb = 16'h000F;
        @(negedge clk);
        check("t4_wr_grant", w_t'(bus.wr_ready), w_t'(1));
        check("t4_mem_wstrb", w_t'(mem_wstrb), w_t'(16'h000F));
        check("t4_mem_wdata", mem_wdata, '1);
        check("t4_mem_addr", w_t'(mem_addr), w_t'(5));
        exp5 = init_word(5);
        exp5[31:0] = '1;
        ref_mem[5] = exp5;
        tick();
        bus.wr_addr = ADDR_W'(6);
        bus.wr_strb = '0;
        @(negedge clk);
        check("t4_zstrb_grant", w_t'(bus.wr_ready), w_t'(1));
        check("t4_zstrb_we", w_t'(mem_en & mem_we), w_t'(1));
        check("t4_zstrb_strb", w_t'(mem_wstrb), w_t'(0));
        tick();
        idle();
        bus.rd_req = 2'b01;
        set_raddr(0, 5);
        @(negedge clk);
        check("t4_rd5_grant", w_t'(bus.rd_ready), w_t'(2'b01));
        push_ret(0, exp5);
        tick();
        bus.rd_req = 2'b10;
        set_raddr(1, 6);
        @(negedge clk);
        check("t4_rd6_grant", w_t'(bus.rd_ready), w_t'(2'b10));
        push_ret(1, init_word(6));
        tick();
        idle();
        repeat (RD_LAT + 1) tick();

        // Reset one cycle after a read grant: outputs drop at once, no return follows.
        bus.rd_req = 2'b01;
        set_raddr(0, 'h10);
        @(negedge clk);
        check("t5_pre_grant", w_t'(bus.rd_ready), w_t'(2'b01));
        tick();
        rstn = 1'b0;
        bus.wr_req = 1'b1;
        @(negedge clk);
        check("t5_rst_rd_ready", w_t'(bus.rd_ready), w_t'(0));
        check("t5_rst_wr_ready", w_t'(bus.wr_ready), w_t'(0));
        check("t5_rst_mem_en", w_t'(mem_en), w_t'(0));
        check("t5_rst_mem_addr", w_t'(mem_addr), w_t'(0));
        check("t5_rst_rd_valid", w_t'(bus.rd_valid), w_t'(0));
        tick();
        rstn = 1'b1;
        idle();
        for (int k = 0; k < int'(RD_LAT) + 1; k++) begin
            @(negedge clk);
            check("t5_no_valid", w_t'(bus.rd_valid), w_t'(0));
            tick();
        end

        // Traffic for the counters: 3 ch1 reads, 2 ch1 stall cycles under writes.
        bus.rd_req = 2'b10;
        set_raddr(1, 'h12);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_rd_grant", w_t'(bus.rd_ready), w_t'(2'b10));
            push_ret(1, ref_mem['h12]);
            tick();
        end
        bus.wr_req  = 1'b1;
        bus.wr_addr = ADDR_W'('h60);
        wd = {$urandom, $urandom, $urandom, $urandom};
        bus.wr_data = wd;
        bus.wr_strb = 16'h001F;
        @(negedge clk);
        check("t6_wr1_grant", w_t'(bus.wr_ready), w_t'(1));
        check("t6_stall1", w_t'(bus.rd_ready), w_t'(0));
        ref_mem['h60] = merge(ref_mem['h60], wd, 16'h001F);
        tick();
        bus.wr_addr = ADDR_W'('h61);
        bus.wr_strb = '0;
        @(negedge clk);
        check("t6_wr2_grant", w_t'(bus.wr_ready), w_t'(1));
        check("t6_stall2", w_t'(bus.rd_ready), w_t'(0));
        tick();
        idle();
`ifdef RAM_PORT_PERF_CNT_EN
        perf_sel = SEL_W'({2'd0, 1'b1});
        tick();
        @(negedge clk);
        check("perf_rd_bytes1", w_t'(perf_data), w_t'(48));
        perf_sel = SEL_W'({2'd1, 1'b1});
        tick();
        @(negedge clk);
        check("perf_rd_stall1", w_t'(perf_data), w_t'(2));
        perf_sel = SEL_W'({2'd2, 1'b0});
        tick();
        @(negedge clk);
        check("perf_wr_bytes", w_t'(perf_data), w_t'(5));
        perf_sel = SEL_W'({2'd3, 1'b1});
        tick();
        @(negedge clk);
        check("perf_wr_stall", w_t'(perf_data), w_t'(0));
        perf_sel = SEL_W'({2'd0, 1'b0});
        tick();
        @(negedge clk);
        check("perf_rd_bytes0", w_t'(perf_data), w_t'(0));
`else
        perf_sel = SEL_W'({2'd0, 1'b1});
        tick();
        @(negedge clk);
        check("perf_tied_zero", w_t'(perf_data), w_t'(0));
`endif
        repeat (RD_LAT + 2) tick();
        check("sb_drained", w_t'(sb_q.size()), w_t'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
